uart_rx_fifo_ctrl: RTL and testbench



---
 rtl/uart_rx_fifo_ctrl.sv | 137 +++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// Purpose : turns each UART_RX frame completion into exactly one write on the RX FIFO write port.
// Latency : rx_done first sampled high at edge N -> fifo_wr_en high in the cycle after edge N+1.
// Backpressure: while fifo_full is high one byte is held; further bytes are dropped and counted (overrun).
//
// Optional feature macro: UART_RX_CTRL_IDLE_TIMEOUT_EN (line-idle gap pulse on idle_timeout).
//
// Ports:
//   rx_clk, reset         baud-domain clock; synchronous active-high reset
//   rx_busy, rx_data,
//   rx_done               UART_RX status, received byte, frame-complete level
//   enable                accept new bytes when 1
//   flush                 single-cycle: drop held byte, clear overrun
//   fifo_full             FIFO write-side full flag
//   fifo_wr_en,
//   fifo_wr_data          registered write strobe and data
//   rx_active             rx_busy OR a byte is held
//   overrun               sticky drop flag
//   byte_cnt, drop_cnt    saturating statistics
//   idle_timeout          one-cycle idle-gap pulse (0 when the macro is undefined)
module uart_rx_fifo_ctrl #(
  parameter int CNT_W        = 16,
  parameter int IDLE_TIMEOUT = 20
) (
  input  logic             rx_clk,
  input  logic             reset,
  input  logic             rx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_wr_data,
  output logic             rx_active,
  output logic             overrun,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             idle_timeout
);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t     state;
  logic [7:0] hold_reg;
  logic       rx_done_q;
  logic       byte_evt;

  // The idle counter is 12 bits wide, so the timeout must fit in it.
  if (IDLE_TIMEOUT < 2 || IDLE_TIMEOUT > 4095) begin : g_bad_idle_timeout
    $error("uart_rx_fifo_ctrl: IDLE_TIMEOUT out of range 2..4095");
  end

  // rx_done is a level that may last several cycles; only its rising edge is a byte.
  assign byte_evt  = enable & rx_done & ~rx_done_q;
  assign rx_active = rx_busy | (state != S_IDLE);

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state        <= S_IDLE;
      hold_reg     <= 8'h00;
      rx_done_q    <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= 8'h00;
      overrun      <= 1'b0;
      byte_cnt     <= '0;
      drop_cnt     <= '0;
    end else begin
      rx_done_q  <= rx_done;
      fifo_wr_en <= 1'b0;
      if (flush) begin
        // Held byte is discarded silently; counters are statistics and survive.
        state   <= S_IDLE;
        overrun <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (byte_evt) begin
              hold_reg <= rx_data;
              state    <= S_PEND;
            end
          end
          S_PEND: begin
            if (!fifo_full) begin
              fifo_wr_en   <= 1'b1;
              fifo_wr_data <= hold_reg;
              if (byte_cnt != {CNT_W{1'b1}}) byte_cnt <= byte_cnt + CNT_W'(1);
              // A byte arriving on the draining edge refills the holding slot.
              if (byte_evt) hold_reg <= rx_data;
              else          state    <= S_IDLE;
            end else if (byte_evt) begin
              // Keep the older byte; the new one is lost.
              overrun <= 1'b1;
              if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UART_RX_CTRL_IDLE_TIMEOUT_EN
  logic [11:0] idle_cnt;
  logic [11:0] idle_cnt_nxt;
  logic        idle_armed;

  assign idle_cnt_nxt = idle_cnt + 12'd1;

  // idle_cnt holds the index of the idle cycle that begins after each edge:
  // the cycle following the write cycle is idle cycle 1, so the pulse lands
  // exactly IDLE_TIMEOUT cycles after the write cycle.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      idle_cnt     <= '0;
      idle_armed   <= 1'b0;
      idle_timeout <= 1'b0;
    end else begin
      idle_timeout <= 1'b0;
      if (fifo_wr_en) begin
        idle_cnt   <= 12'd1;
        idle_armed <= 1'b1;
      end else if (rx_busy) begin
        idle_cnt <= '0;
      end else if (idle_armed) begin
        idle_cnt <= idle_cnt_nxt;
        if (idle_cnt_nxt == 12'(IDLE_TIMEOUT)) begin
          idle_timeout <= 1'b1;
          idle_armed   <= 1'b0;
        end
      end
    end
  end
`else
  assign idle_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Purpose : directed stimulus for uart_rx_fifo_ctrl with a write scoreboard.
// Latency : expected writes carry the exact cycle they must appear in.
// Backpressure: fifo_full is driven directly to exercise hold, drop and flush.
module tb_uart_rx_fifo_ctrl;

  localparam int CNT_W = 3;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_busy;
  logic [7:0]       rx_data;
  logic             rx_done;
  logic             enable;
  logic             flush;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [7:0]       fifo_wr_data;
  logic             rx_active;
  logic             overrun;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic             idle_timeout;

  uart_rx_fifo_ctrl #(.CNT_W(CNT_W), .IDLE_TIMEOUT(TMO)) dut (
    .rx_clk(clk), .reset(reset), .rx_busy(rx_busy), .rx_data(rx_data),
    .rx_done(rx_done), .enable(enable), .flush(flush), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .rx_active(rx_active),
    .overrun(overrun), .byte_cnt(byte_cnt), .drop_cnt(drop_cnt),
    .idle_timeout(idle_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   nbytes = 0;
  logic full_q = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    full_q <= fifo_full;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int n);
    return (n > 7) ? 7 : n;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [7:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    q.push_back(e);
    nbytes++;
  endtask

  // rx_done high for len cycles, then one low cycle.
  task automatic pulse_done(input logic [7:0] d, input int len);
    rx_data = d;
    rx_done = 1'b1;
    tick(len);
    rx_done = 1'b0;
    tick(1);
  endtask

  // Monitor: every write must match the next scoreboard entry in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && fifo_wr_en) begin
      chk("wr_while_full", {31'd0, full_q}, 32'd0);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: data %0h at cycle %0d, nothing expected", fifo_wr_data, cyc);
      end else begin
        e = q.pop_front();
        chk("wr_data", {24'd0, fifo_wr_data}, {24'd0, e.d});
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int npulse;
    int pcyc;
    reset = 1'b1; rx_busy = 1'b1; rx_data = 8'h00; rx_done = 1'b0;
    enable = 1'b1; flush = 1'b0; fifo_full = 1'b0;

    // Reset held three cycles
    tick(3);
    chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, fifo_wr_data}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_byte_cnt", {29'd0, byte_cnt}, 32'd0);
    chk("rst_drop_cnt", {29'd0, drop_cnt}, 32'd0);
    chk("rst_idle_timeout", {31'd0, idle_timeout}, 32'd0);
    chk("rst_rx_active_busy", {31'd0, rx_active}, 32'd1);
    rx_busy = 1'b0;
    #1;
    chk("rst_rx_active_idle", {31'd0, rx_active}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Single byte: write two cycles after rx_done is sampled
    expect_wr(8'h3C, cyc + 2);
    rx_data = 8'h3C; rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    chk("single_rx_active", {31'd0, rx_active}, 32'd1);
    tick(3);
    chk("single_byte_cnt", {29'd0, byte_cnt}, 32'd1);

    // Long rx_done level gives one write
    expect_wr(8'h9D, cyc + 2);
    pulse_done(8'h9D, 4);
    tick(3);
    chk("long_byte_cnt", {29'd0, byte_cnt}, sat(nbytes));

    // Backpressure: full sampled for six edges around 0xA5
    fifo_full = 1'b1;
    tick(1);
    rx_data = 8'hA5; rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
    tick(4);
    chk("bp_held_active", {31'd0, rx_active}, 32'd1);
    chk("bp_byte_cnt_hold", {29'd0, byte_cnt}, 32'd2);
    fifo_full = 1'b0;
    expect_wr(8'hA5, cyc + 1);
    tick(4);
    chk("bp_byte_cnt", {29'd0, byte_cnt}, sat(nbytes));
    chk("bp_rx_active", {31'd0, rx_active}, 32'd0);

    // Overrun: 0x5A dropped while 0xA5 held, then flush
    fifo_full = 1'b1;
    pulse_done(8'hA5, 1);
    pulse_done(8'h5A, 1);
    tick(2);
    chk("ovr_overrun", {31'd0, overrun}, 32'd1);
    chk("ovr_drop_cnt", {29'd0, drop_cnt}, 32'd1);
    fifo_full = 1'b0;
    expect_wr(8'hA5, cyc + 1);
    tick(3);
    chk("ovr_byte_cnt", {29'd0, byte_cnt}, sat(nbytes));
    chk("ovr_drop_keep", {29'd0, drop_cnt}, 32'd1);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_overrun", {31'd0, overrun}, 32'd0);
    chk("flush_drop_cnt", {29'd0, drop_cnt}, 32'd1);

    // Byte arriving on the draining edge is captured, not dropped
    fifo_full = 1'b1;
    pulse_done(8'h11, 1);
    tick(1);
    fifo_full = 1'b0;
    rx_data = 8'h22; rx_done = 1'b1;
    expect_wr(8'h11, cyc + 1);
    expect_wr(8'h22, cyc + 2);
    tick(1);
    rx_done = 1'b0;
    tick(3);
    chk("refill_drop_cnt", {29'd0, drop_cnt}, 32'd1);
    chk("refill_byte_cnt", {29'd0, byte_cnt}, sat(nbytes));

    // Flush discards the held byte and ignores a same-cycle byte
    fifo_full = 1'b1;
    pulse_done(8'h33, 1);
    flush = 1'b1; rx_data = 8'h44; rx_done = 1'b1;
    tick(1);
    flush = 1'b0; rx_done = 1'b0;
    chk("flush_rx_active", {31'd0, rx_active}, 32'd0);
    fifo_full = 1'b0;
    tick(3);
    chk("flush_byte_cnt", {29'd0, byte_cnt}, sat(nbytes));
    chk("flush_drop_keep", {29'd0, drop_cnt}, 32'd1);

    // Disabled: bytes ignored, not counted as drops
    enable = 1'b0;
    pulse_done(8'h55, 1);
    tick(2);
    chk("dis_rx_active", {31'd0, rx_active}, 32'd0);
    chk("dis_drop_cnt", {29'd0, drop_cnt}, 32'd1);
    chk("dis_byte_cnt", {29'd0, byte_cnt}, sat(nbytes));
    enable = 1'b1;
    tick(12);

    // Idle timeout after a lone write
    wc = cyc + 2;
    expect_wr(8'h3C, wc);
    pulse_done(8'h3C, 1);
    npulse = 0;
    pcyc   = -1;
    repeat (24) begin
      @(negedge clk);
      if (idle_timeout) begin
        npulse++;
        pcyc = cyc;
      end
    end
    #1;
`ifdef UART_RX_CTRL_IDLE_TIMEOUT_EN
    chk("tmo_pulses", npulse, 1);
    chk("tmo_cycle", pcyc, wc + TMO);
`else
    chk("tmo_pulses", npulse, 0);
`endif

    // Counter saturation
    for (int i = 0; i < 3; i++) begin
      expect_wr(8'hC0 + 8'(i), cyc + 2);
      pulse_done(8'hC0 + 8'(i), 1);
      tick(1);
    end
    tick(2);
    chk("sat_byte_cnt", {29'd0, byte_cnt}, 32'd7);
    fifo_full = 1'b1;
    pulse_done(8'hE0, 1);
    for (int i = 0; i < 8; i++) pulse_done(8'hF0 + 8'(i), 1);
    chk("sat_drop_cnt", {29'd0, drop_cnt}, 32'd7);
    fifo_full = 1'b0;
    expect_wr(8'hE0, cyc + 1);
    tick(3);
    chk("sat_byte_hold", {29'd0, byte_cnt}, 32'd7);

    // Reset while a byte is held
    fifo_full = 1'b1;
    pulse_done(8'h66, 1);
    chk("rstp_rx_active", {31'd0, rx_active}, 32'd1);
    reset = 1'b1;
    tick(1);
    chk("rstp_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    chk("rstp_wr_data", {24'd0, fifo_wr_data}, 32'd0);
    chk("rstp_overrun", {31'd0, overrun}, 32'd0);
    chk("rstp_byte_cnt", {29'd0, byte_cnt}, 32'd0);
    chk("rstp_drop_cnt", {29'd0, drop_cnt}, 32'd0);
    chk("rstp_rx_active0", {31'd0, rx_active}, 32'd0);
    reset = 1'b0;
    nbytes = 0;
    fifo_full = 1'b0;
    tick(4);
    chk("rstp_no_write", {29'd0, byte_cnt}, 32'd0);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
